// File: rtl/onewire_slave_pkg.sv
// onewire_slave_pkg: shared states, commands, scratchpad bytes and
// microsecond timing constants for the 1-Wire temperature slave.
package onewire_slave_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE       = 4'd0;
  localparam state_t S_RESET_WAIT = 4'd1;
  localparam state_t S_PRES_DELAY = 4'd2;
  localparam state_t S_PRES_DRIVE = 4'd3;
  localparam state_t S_ROM_CMD    = 4'd4;
  localparam state_t S_ROM_SEND   = 4'd5;
  localparam state_t S_FUNC_CMD   = 4'd6;
  localparam state_t S_TX_BYTES   = 4'd7;
  localparam state_t S_CONV_POLL  = 4'd8;

  localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
  localparam logic [7:0] CMD_READ_ROM = 8'h33;
  localparam logic [7:0] CMD_CONVERT  = 8'h44;
  localparam logic [7:0] CMD_READ_SP  = 8'hBE;

  localparam logic [7:0] SP_TH   = 8'h4B;
  localparam logic [7:0] SP_TL   = 8'h46;
  localparam logic [7:0] SP_CFG  = 8'h7F;
  localparam logic [7:0] SP_RES0 = 8'hFF;
  localparam logic [7:0] SP_RES1 = 8'h0C;
  localparam logic [7:0] SP_RES2 = 8'h10;

  localparam logic [15:0] TEMP_RST = 16'h0550;

  localparam int T_RST_US   = 480;
  localparam int T_PDLY_US  = 30;
  localparam int T_PRES_US  = 120;
  localparam int T_SLOT_US  = 30;
  localparam int T_GUARD_US = 2;

  // Scratchpad byte by index; index 8 and above is the CRC.
  function automatic logic [7:0] sp_byte(
    input logic [3:0]  idx,
    input logic [15:0] temp,
    input logic [7:0]  crc
  );
    logic [7:0] b;
    b = crc;
    case (idx)
      4'd0: b = temp[7:0];
      4'd1: b = temp[15:8];
      4'd2: b = SP_TH;
      4'd3: b = SP_TL;
      4'd4: b = SP_CFG;
      4'd5: b = SP_RES0;
      4'd6: b = SP_RES1;
      4'd7: b = SP_RES2;
      default: b = crc;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/onewire_crc8.sv
// onewire_crc8: serial Dallas CRC8 (x^8+x^5+x^4+1), LSB-first data.
// Ports: clk, rst (async high), clr, en, d (data bit), crc (result).
module onewire_crc8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       d,
  output logic [7:0] crc
);

  logic fb;

  assign fb = crc[0] ^ d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= 8'h00;
    end else if (clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= {fb, crc[7:5], crc[4] ^ fb, crc[3] ^ fb, crc[2:1]};
    end
  end

endmodule

// File: rtl/onewire_slave.sv
// onewire_slave: 1-Wire temperature sensor slave (skip ROM, convert,
// read scratchpad). Optional read-ROM via ONEWIRE_SLAVE_READ_ROM_EN.
// Ports: clk, rst (async high), line (open drain), temp_i (1/16 C),
// cmd_o/cmd_strb (last function command), busy (conversion running).
module onewire_slave
  import onewire_slave_pkg::*;
#(
  parameter int          FREQ     = 27,
  parameter int          CONV_US  = 1000,
  parameter logic [63:0] ROM_CODE = 64'h2800_0000_0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire         line,
  input  logic [15:0] temp_i,
  output logic [7:0]  cmd_o,
  output logic        cmd_strb,
  output logic        busy
);

  localparam int RST_CYC  = T_RST_US * FREQ;
  localparam int PDLY_CYC = T_PDLY_US * FREQ;
  localparam int PRES_CYC = T_PRES_US * FREQ;
  localparam int SLOT_CYC = T_SLOT_US * FREQ;
  localparam int GRD_CYC  = T_GUARD_US * FREQ;
  localparam int CONV_CYC = CONV_US * FREQ;
  localparam int TW       = $clog2(RST_CYC + 1);
  localparam int CW       = $clog2(CONV_CYC + 1);

  state_t          state;
  logic            s1, s2, s3;
  logic [TW-1:0]   low_cnt;
  logic [TW-1:0]   tmr;
  logic            slot_on, slot_rd, grd_on, drive;
  logic [7:0]      rx;
  logic [7:0]      rx_byte;
  logic [6:0]      bcnt;
  logic [CW-1:0]   conv_tmr;
  logic [15:0]     temp_q;
  logic            crc_clr, crc_en, crc_d;
  logic [7:0]      crc;
  logic [7:0]      sp_q;
  logic            tx_bit;
  logic            fall, bus_rst;
  logic            rx_st, tx_st;
  logic            slot_go, slot_end;
  logic            conv_start;

  assign line = drive ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= line;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall    = s3 & ~s2;
  assign bus_rst = ~s2 && (low_cnt == TW'(RST_CYC - 1));

  // Saturating low-time counter; a long enough low aborts everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      low_cnt <= '0;
    end else if (s2) begin
      low_cnt <= '0;
    end else if (low_cnt != TW'(RST_CYC)) begin
      low_cnt <= low_cnt + 1'b1;
    end
  end

  assign rx_st    = (state == S_ROM_CMD) || (state == S_FUNC_CMD);
  assign tx_st    = (state == S_ROM_SEND) || (state == S_TX_BYTES) ||
                    (state == S_CONV_POLL);
  assign slot_go  = fall & ~slot_on & ~grd_on & (rx_st | tx_st);
  assign slot_end = slot_on && (tmr == TW'(SLOT_CYC - 1));
  assign rx_byte  = {s2, rx[7:1]};
  assign sp_q     = sp_byte(bcnt[6:3], temp_q, crc);

  always_comb begin
    tx_bit = 1'b1;
    case (state)
      S_ROM_SEND:  tx_bit = ROM_CODE[bcnt[5:0]];
      S_TX_BYTES:  tx_bit = sp_q[bcnt[2:0]];
      S_CONV_POLL: tx_bit = ~busy;
      default:     tx_bit = 1'b1;
    endcase
  end

  assign conv_start = ~bus_rst & grd_ok_n() & slot_end & ~slot_rd &
                      (state == S_FUNC_CMD) && (bcnt[2:0] == 3'd7) &&
                      (rx_byte == CMD_CONVERT);

  function automatic logic grd_ok_n();
    return ~grd_on;
  endfunction

  // The conversion timer ignores bus resets; only rst stops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      conv_tmr <= '0;
      temp_q   <= TEMP_RST;
    end else if (conv_start) begin
      busy     <= 1'b1;
      conv_tmr <= '0;
    end else if (busy) begin
      if (conv_tmr == CW'(CONV_CYC - 1)) begin
        busy   <= 1'b0;
        temp_q <= temp_i;
      end else begin
        conv_tmr <= conv_tmr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tmr      <= '0;
      slot_on  <= 1'b0;
      slot_rd  <= 1'b0;
      grd_on   <= 1'b0;
      drive    <= 1'b0;
      rx       <= 8'h00;
      bcnt     <= '0;
      cmd_o    <= 8'h00;
      cmd_strb <= 1'b0;
      crc_clr  <= 1'b0;
      crc_en   <= 1'b0;
      crc_d    <= 1'b0;
    end else begin
      cmd_strb <= 1'b0;
      crc_clr  <= 1'b0;
      crc_en   <= 1'b0;
      if (bus_rst) begin
        state   <= S_RESET_WAIT;
        slot_on <= 1'b0;
        grd_on  <= 1'b0;
        drive   <= 1'b0;
        tmr     <= '0;
      end else begin
        case (state)
          S_IDLE: begin
          end
          S_RESET_WAIT: begin
            if (s2) begin
              state <= S_PRES_DELAY;
              tmr   <= '0;
            end
          end
          S_PRES_DELAY: begin
            if (tmr == TW'(PDLY_CYC - 1)) begin
              state <= S_PRES_DRIVE;
              drive <= 1'b1;
              tmr   <= '0;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          S_PRES_DRIVE: begin
            if (tmr == TW'(PRES_CYC - 1)) begin
              state  <= S_ROM_CMD;
              drive  <= 1'b0;
              grd_on <= 1'b1;
              tmr    <= '0;
              bcnt   <= '0;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          default: begin
            if (grd_on) begin
              // Our own release can look like a fresh falling edge.
              if (tmr == TW'(GRD_CYC - 1)) begin
                grd_on <= 1'b0;
                tmr    <= '0;
              end else begin
                tmr <= tmr + 1'b1;
              end
            end else if (slot_go) begin
              slot_on <= 1'b1;
              slot_rd <= tx_st;
              tmr     <= '0;
              if (tx_st) begin
                drive <= ~tx_bit;
                if (state == S_TX_BYTES && !bcnt[6]) begin
                  crc_en <= 1'b1;
                  crc_d  <= tx_bit;
                end
              end
            end else if (slot_on) begin
              if (!slot_end) begin
                tmr <= tmr + 1'b1;
              end else if (slot_rd) begin
                slot_on <= 1'b0;
                drive   <= 1'b0;
                grd_on  <= 1'b1;
                tmr     <= '0;
                bcnt    <= bcnt + 1'b1;
                if (state == S_ROM_SEND && bcnt == 7'd63) begin
                  state <= S_FUNC_CMD;
                  bcnt  <= '0;
                end
                if (state == S_TX_BYTES && bcnt == 7'd71) begin
                  state <= S_IDLE;
                end
              end else begin
                slot_on <= 1'b0;
                tmr     <= '0;
                rx      <= rx_byte;
                bcnt    <= bcnt + 1'b1;
                if (bcnt[2:0] == 3'd7) begin
                  bcnt <= '0;
                  if (state == S_ROM_CMD) begin
                    if (rx_byte == CMD_SKIP_ROM) begin
                      state <= S_FUNC_CMD;
`ifdef ONEWIRE_SLAVE_READ_ROM_EN
                    end else if (rx_byte == CMD_READ_ROM) begin
                      state <= S_ROM_SEND;
`endif
                    end else begin
                      state <= S_IDLE;
                    end
                  end else begin
                    cmd_o    <= rx_byte;
                    cmd_strb <= 1'b1;
                    if (rx_byte == CMD_READ_SP) begin
                      state   <= S_TX_BYTES;
                      crc_clr <= 1'b1;
                    end else if (rx_byte == CMD_CONVERT) begin
                      state <= S_CONV_POLL;
                    end else begin
                      state <= S_IDLE;
                    end
                  end
                end
              end
            end
          end
        endcase
      end
    end
  end

  onewire_crc8 u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .d   (crc_d),
    .crc (crc)
  );

endmodule

// File: tb/tb_onewire_slave.sv
// tb_onewire_slave: randomized 1-Wire master with a scoreboard that
// checks presence, conversion polling, scratchpad readout and ROM.
`timescale 1ns/1ps
module tb_onewire_slave;

  localparam int          FREQ    = 1;
  localparam int          CONV_US = 800;
  localparam logic [63:0] ROM     = 64'hB7E1_5A3C_0000_0128;
  localparam int          CLK_NS  = 10;
  localparam int          US      = CLK_NS * FREQ;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] temp_i;
  logic        m_low;
  wire  [7:0]  cmd_o;
  wire         cmd_strb;
  wire         busy;
  wire         line;

  assign line = m_low ? 1'b0 : 1'bz;
  pullup (line);

  always #(CLK_NS / 2) clk = ~clk;

  onewire_slave #(
    .FREQ     (FREQ),
    .CONV_US  (CONV_US),
    .ROM_CODE (ROM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .line     (line),
    .temp_i   (temp_i),
    .cmd_o    (cmd_o),
    .cmd_strb (cmd_strb),
    .busy     (busy)
  );

  typedef struct {
    string tag;
    int    kind;
    logic  val;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] cmd_q[$];
  event       samp_ev;
  int         errors = 0;
  int         checks = 0;
  time        conv_end = 0;
  time        last_wr_fall = 0;
  logic [7:0] cexp;

  task automatic chk(input string tag, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", tag, act, req);
    end
  endtask

  // Scoreboard monitor: compares every queued expectation at the
  // moment the driver flags a sample point.
  initial begin
    exp_t e;
    forever begin
      @(samp_ev);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.kind == 0) chk(e.tag, int'(line), int'(e.val));
        else chk(e.tag, int'(busy), int'(e.val));
      end
    end
  end

  always @(negedge clk) begin
    if (cmd_strb) begin
      if (cmd_q.size() == 0) begin
        chk("cmd_strb_unexpected", 1, 0);
      end else begin
        cexp = cmd_q.pop_front();
        chk("cmd_o", int'(cmd_o), int'(cexp));
      end
    end
  end

  initial begin
    #(200_000 * CLK_NS);
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Reference scratchpad: fixed layout plus software CRC over 8 bytes.
  function automatic logic [7:0] sp_m(input logic [15:0] t, input int idx);
    logic [7:0] d[9];
    logic [7:0] c;
    logic [7:0] b;
    d[0] = t[7:0];
    d[1] = t[15:8];
    d[2] = 8'h4B;
    d[3] = 8'h46;
    d[4] = 8'h7F;
    d[5] = 8'hFF;
    d[6] = 8'h0C;
    d[7] = 8'h10;
    c = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b = d[i];
      for (int k = 0; k < 8; k++) begin
        if ((c[0] ^ b[0]) == 1'b1) c = (c >> 1) ^ 8'h8C;
        else c = c >> 1;
        b = b >> 1;
      end
    end
    d[8] = c;
    return d[idx];
  endfunction

  task automatic push(input string tag, input int kind, input logic v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = v;
    exp_q.push_back(e);
    -> samp_ev;
  endtask

  task automatic bus_reset(input bit pres);
    m_low = 1'b1;
    #(500 * US);
    m_low = 1'b0;
    if (pres) begin
      #(15 * US);  push("pres_before", 0, 1'b1);
      #(25 * US);  push("pres_start", 0, 1'b0);
      #(105 * US); push("pres_hold", 0, 1'b0);
      #(20 * US);  push("pres_end", 0, 1'b1);
      #(35 * US);
    end else begin
      #(200 * US);
    end
  endtask

  task automatic write_bit(input logic b);
    m_low = 1'b1;
    if (b) begin
      #(5 * US);
      m_low = 1'b0;
      #(40 * US);
    end else begin
      #(40 * US);
      m_low = 1'b0;
      #(5 * US);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      last_wr_fall = $time;
      write_bit(b[i]);
    end
  endtask

  task automatic func_cmd(input logic [7:0] b);
    cmd_q.push_back(b);
    write_byte(b);
    if (b == 8'h44) conv_end = last_wr_fall + (30 + CONV_US) * US;
  endtask

  task automatic read_slot(input string tag, input bit dl, input logic lv,
                           input bit db, input logic bv);
    m_low = 1'b1;
    #(5 * US);
    m_low = 1'b0;
    #(7 * US);
    if (dl) push(tag, 0, lv);
    if (db) push({tag, "_busy"}, 1, bv);
    #(33 * US);
  endtask

  task automatic poll_slot();
    time tf;
    tf = $time;
    if (tf + 20 * US < conv_end) read_slot("poll", 1, 1'b0, 1, 1'b1);
    else if (tf > conv_end + 20 * US) read_slot("poll", 1, 1'b1, 1, 1'b0);
    else read_slot("poll", 0, 1'b0, 0, 1'b0);
  endtask

  task automatic read_sp(input logic [15:0] t, input int n);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = sp_m(t, i / 8);
      read_slot("sp_bit", 1, d[i % 8], 0, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] t;
    logic [7:0]  j;
    logic [63:0] rom;
    rst    = 1'b1;
    m_low  = 1'b0;
    temp_i = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_o", int'(cmd_o), 8'h00);
    chk("rst_cmd_strb", int'(cmd_strb), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_line", int'(line), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Power-on scratchpad temperature.
    bus_reset(1);
    write_byte(8'hCC);
    func_cmd(8'hBE);
    read_sp(16'h0550, 16);

    // Conversion with polling.
    temp_i = 16'h0191;
    bus_reset(1);
    write_byte(8'hCC);
    func_cmd(8'h44);
    for (int i = 0; i < 24; i++) poll_slot();

    // Full scratchpad with CRC, then trailing ones.
    bus_reset(1);
    write_byte(8'hCC);
    func_cmd(8'hBE);
    read_sp(16'h0191, 72);
    read_slot("after_sp", 1, 1'b1, 0, 1'b0);
    read_slot("after_sp", 1, 1'b1, 0, 1'b0);

    // Abort mid-readout, restart at byte 0.
    bus_reset(1);
    write_byte(8'hCC);
    func_cmd(8'hBE);
    read_sp(16'h0191, 20);
    bus_reset(1);
    write_byte(8'hCC);
    func_cmd(8'hBE);
    read_sp(16'h0191, 72);

    // Random temperatures; bus reset during conversion.
    for (int k = 0; k < 3; k++) begin
      t = 16'($urandom_range(0, 65535));
      temp_i = t;
      bus_reset(1);
      write_byte(8'hCC);
      func_cmd(8'h44);
      m_low = 1'b1;
      #(500 * US);
      m_low = 1'b0;
      #(5 * US);
      if ($time + 20 * US < conv_end) push("busy_across_reset", 1, 1'b1);
      #(195 * US);
      while ($time < conv_end + 20 * US) #(10 * US);
      push("busy_done", 1, 1'b0);
      temp_i = 16'($urandom_range(0, 65535));
      bus_reset(1);
      write_byte(8'hCC);
      func_cmd(8'hBE);
      read_sp(t, 72);
    end

    // Unknown ROM commands leave the bus alone.
    bus_reset(1);
    write_byte(8'h55);
    for (int i = 0; i < 4; i++) read_slot("unknown_rom", 1, 1'b1, 0, 1'b0);
    do j = 8'($urandom_range(0, 255)); while (j == 8'hCC || j == 8'h33);
    bus_reset(1);
    write_byte(j);
    for (int i = 0; i < 4; i++) read_slot("unknown_rom", 1, 1'b1, 0, 1'b0);

    // Read ROM.
    rom = ROM;
    bus_reset(1);
    write_byte(8'h33);
    for (int i = 0; i < 64; i++) begin
`ifdef ONEWIRE_SLAVE_READ_ROM_EN
      read_slot("rom_bit", 1, rom[i], 0, 1'b0);
`else
      read_slot("rom_off", 1, 1'b1, 0, 1'b0);
`endif
    end

    #(100 * US);
    chk("cmd_pending", cmd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
